// File: rtl/alu_ctrl.sv
// alu_ctrl: execute-stage controller that issues registered operands to an external 4-bit ALU.
// Define ALU_CTRL_ZFLAG_EN to add the registered `zero` flag port and its update logic.
module alu_ctrl #(
   parameter int unsigned ALU_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       instr_valid,
   input  logic [7:0] instr,
   output logic       instr_ready,
   output logic [3:0] alu_a,
   output logic [3:0] alu_b,
   output logic [2:0] alu_sel,
   output logic       alu_cin,
   input  logic [3:0] alu_out,
   input  logic       alu_cout,
   output logic [3:0] acc,
   output logic [3:0] breg,
   output logic       carry,
   output logic       done
`ifdef ALU_CTRL_ZFLAG_EN
   ,
   output logic       zero
`endif
);

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_ISSUE = 1'b1;

   localparam logic [2:0] OP_LDA = 3'b000;
   localparam logic [2:0] OP_LDB = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_MOV = 3'b111;

   localparam logic [3:0] CNT_INIT = 4'(ALU_LAT - 1);

   logic [0:0] state;
   logic [3:0] cnt;
   logic       take;
   logic       capture;
   logic [2:0] op;
   logic [3:0] imm;

   assign instr_ready = (state == S_IDLE);
   assign take        = instr_valid && instr_ready;
   assign capture     = (state == S_ISSUE) && (cnt == '0);
   assign op          = instr[7:5];
   assign imm         = instr[3:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         acc     <= '0;
         breg    <= '0;
         carry   <= 1'b0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_sel <= '0;
         alu_cin <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (take) begin
                  case (op)
                     OP_LDA: begin
                        acc  <= imm;
                        done <= 1'b1;
                     end
                     OP_LDB: begin
                        breg <= imm;
                        done <= 1'b1;
                     end
                     default: begin
                        // MOV swaps the operands so the ALU pass-through of in_A yields B
                        alu_a   <= (op == OP_MOV) ? breg : acc;
                        alu_b   <= (op == OP_MOV) ? acc : breg;
                        alu_sel <= op;
                        alu_cin <= instr[4] & carry;
                        cnt     <= CNT_INIT;
                        state   <= S_ISSUE;
                     end
                  endcase
               end
            end
            default: begin
               if (!capture) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  acc <= alu_out;
                  if (alu_sel == OP_ADD || alu_sel == OP_SUB) begin
                     carry <= alu_cout;
                  end
                  alu_sel <= '0;
                  done    <= 1'b1;
                  state   <= S_IDLE;
               end
            end
         endcase
      end
   end

`ifdef ALU_CTRL_ZFLAG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         zero <= 1'b1;
      end else if (take && op == OP_LDA) begin
         zero <= (imm == '0);
      end else if (capture) begin
         zero <= (alu_out == '0);
      end
   end
`endif

endmodule

// File: tb/tb_alu_ctrl.sv
// Self-checking bench for alu_ctrl: two instances (ALU_LAT=1 and 3), each with a behavioural ALU.
// A transaction-level model of the A/B/carry/zero registers predicts every observed value.
module tb_alu_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic       rst_v   [2];
   logic       valid_v [2];
   logic [7:0] instr_v [2];

   logic       ready0, ready1, cin0, cin1, cout0, cout1, carry0, carry1, done0, done1;
   logic [3:0] a0, a1, b0, b1, out0, out1, acc0, acc1, breg0, breg1;
   logic [2:0] sel0, sel1;
`ifdef ALU_CTRL_ZFLAG_EN
   logic       zero0, zero1;
`endif

   logic       ready_v [2];
   logic       cin_v   [2];
   logic       carry_v [2];
   logic       done_v  [2];
   logic [3:0] a_v     [2];
   logic [3:0] b_v     [2];
   logic [3:0] acc_v   [2];
   logic [3:0] breg_v  [2];
   logic [2:0] sel_v   [2];

   // reference model state
   logic [3:0] m_a [2];
   logic [3:0] m_b [2];
   logic       m_c [2];
   logic       m_z [2];

   // behavioural 4-bit ALU: SUB reports borrow on carry_out
   function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b,
                                        input logic [2:0] s, input logic ci);
      case (s)
         3'b010:  return {1'b0, a} + {1'b0, b} + 5'(ci);
         3'b011:  return {1'b0, a} - {1'b0, b} - 5'(ci);
         3'b100:  return {1'b0, a & b};
         3'b101:  return {1'b0, a | b};
         3'b110:  return {1'b0, a ^ b};
         3'b111:  return {1'b0, a};
         default: return 5'b0;
      endcase
   endfunction

   assign {cout0, out0} = alu_f(a0, b0, sel0, cin0);
   assign {cout1, out1} = alu_f(a1, b1, sel1, cin1);

   alu_ctrl #(.ALU_LAT(1)) dut0 (
      .clk(clk), .rst(rst_v[0]), .instr_valid(valid_v[0]), .instr(instr_v[0]),
      .instr_ready(ready0), .alu_a(a0), .alu_b(b0), .alu_sel(sel0), .alu_cin(cin0),
      .alu_out(out0), .alu_cout(cout0), .acc(acc0), .breg(breg0), .carry(carry0),
      .done(done0)
`ifdef ALU_CTRL_ZFLAG_EN
      , .zero(zero0)
`endif
   );

   alu_ctrl #(.ALU_LAT(3)) dut1 (
      .clk(clk), .rst(rst_v[1]), .instr_valid(valid_v[1]), .instr(instr_v[1]),
      .instr_ready(ready1), .alu_a(a1), .alu_b(b1), .alu_sel(sel1), .alu_cin(cin1),
      .alu_out(out1), .alu_cout(cout1), .acc(acc1), .breg(breg1), .carry(carry1),
      .done(done1)
`ifdef ALU_CTRL_ZFLAG_EN
      , .zero(zero1)
`endif
   );

   always_comb begin
      ready_v[0] = ready0; ready_v[1] = ready1;
      cin_v[0]   = cin0;   cin_v[1]   = cin1;
      carry_v[0] = carry0; carry_v[1] = carry1;
      done_v[0]  = done0;  done_v[1]  = done1;
      a_v[0]     = a0;     a_v[1]     = a1;
      b_v[0]     = b0;     b_v[1]     = b1;
      acc_v[0]   = acc0;   acc_v[1]   = acc1;
      breg_v[0]  = breg0;  breg_v[1]  = breg1;
      sel_v[0]   = sel0;   sel_v[1]   = sel1;
   end

   function automatic int unsigned lat_of(input int d);
      return (d == 0) ? 1 : 3;
   endfunction

   function automatic logic zero_of(input int d);
`ifdef ALU_CTRL_ZFLAG_EN
      return (d == 0) ? zero0 : zero1;
`else
      return m_z[d];
`endif
   endfunction

   task automatic model_reset(input int d);
      m_a[d] = '0; m_b[d] = '0; m_c[d] = 1'b0; m_z[d] = 1'b1;
   endtask

   // Presents one instruction and checks every cycle until it retires.
   task automatic exec(input int d, input logic [7:0] ins);
      logic [2:0]  op;
      logic [3:0]  imm, ea, eb, res;
      logic        ecin, nc;
      logic [4:0]  full;
      int unsigned n;
      op  = ins[7:5];
      imm = ins[3:0];
      n   = 0;
      while (ready_v[d] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      tests_run++;
      if (ready_v[d] !== 1'b1) begin
         tests_failed++;
         $display("FAIL ready_before_issue dut%0d: got %b, want 1", d, ready_v[d]);
      end
      valid_v[d] = 1'b1;
      instr_v[d] = ins;
      @(negedge clk);
      valid_v[d] = 1'b0;
      if (op == 3'b000) begin
         m_a[d] = imm;
         m_z[d] = (imm == 4'd0);
      end else if (op == 3'b001) begin
         m_b[d] = imm;
      end else begin
         ea   = (op == 3'b111) ? m_b[d] : m_a[d];
         eb   = (op == 3'b111) ? m_a[d] : m_b[d];
         ecin = ins[4] & m_c[d];
         nc   = m_c[d];
         full = '0;
         case (op)
            3'b010: begin full = 5'(m_a[d]) + 5'(m_b[d]) + 5'(ecin); res = full[3:0]; nc = full[4]; end
            3'b011: begin full = 5'(m_a[d]) - 5'(m_b[d]) - 5'(ecin); res = full[3:0]; nc = full[4]; end
            3'b100: res = m_a[d] & m_b[d];
            3'b101: res = m_a[d] | m_b[d];
            3'b110: res = m_a[d] ^ m_b[d];
            default: res = m_b[d];
         endcase
         for (int unsigned k = 0; k < lat_of(d); k++) begin
            if (k != 0) @(negedge clk);
            tests_run++;
            if ({a_v[d], b_v[d], sel_v[d], cin_v[d], ready_v[d], done_v[d], acc_v[d]} !==
                {ea, eb, op, ecin, 1'b0, 1'b0, m_a[d]}) begin
               tests_failed++;
               $display("FAIL issue_hold dut%0d op%0d cyc%0d: got a=%h b=%h sel=%h cin=%b rdy=%b done=%b acc=%h, want a=%h b=%h sel=%h cin=%b rdy=0 done=0 acc=%h",
                        d, op, k, a_v[d], b_v[d], sel_v[d], cin_v[d], ready_v[d], done_v[d], acc_v[d],
                        ea, eb, op, ecin, m_a[d]);
            end
         end
         @(negedge clk);
         m_a[d] = res;
         m_c[d] = nc;
         m_z[d] = (res == 4'd0);
      end
      tests_run++;
      if ({acc_v[d], breg_v[d], carry_v[d], done_v[d], ready_v[d], sel_v[d]} !==
          {m_a[d], m_b[d], m_c[d], 1'b1, 1'b1, 3'b000}) begin
         tests_failed++;
         $display("FAIL retire dut%0d ins=%h: got acc=%h b=%h c=%b done=%b rdy=%b sel=%h, want acc=%h b=%h c=%b done=1 rdy=1 sel=0",
                  d, ins, acc_v[d], breg_v[d], carry_v[d], done_v[d], ready_v[d], sel_v[d],
                  m_a[d], m_b[d], m_c[d]);
      end
`ifdef ALU_CTRL_ZFLAG_EN
      tests_run++;
      if (zero_of(d) !== m_z[d]) begin
         tests_failed++;
         $display("FAIL zero_flag dut%0d ins=%h: got %b, want %b", d, ins, zero_of(d), m_z[d]);
      end
`endif
   endtask

   task automatic test_reset;
      rst_v[0] = 1'b1; rst_v[1] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst_v[0] = 1'b0; rst_v[1] = 1'b0;
      for (int d = 0; d < 2; d++) begin
         model_reset(d);
         tests_run++;
         if ({acc_v[d], breg_v[d], carry_v[d], done_v[d], ready_v[d], sel_v[d], a_v[d], b_v[d], cin_v[d], zero_of(d)} !==
             {4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 3'b000, 4'h0, 4'h0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_state dut%0d: got acc=%h b=%h c=%b done=%b rdy=%b sel=%h a=%h b=%h cin=%b z=%b, want all 0 except rdy=1 z=1",
                     d, acc_v[d], breg_v[d], carry_v[d], done_v[d], ready_v[d], sel_v[d], a_v[d], b_v[d], cin_v[d], zero_of(d));
         end
      end
   endtask

   task automatic test_add;
      exec(0, 8'b000_0_0101);
      exec(0, 8'b001_0_0011);
      exec(0, 8'b010_1_0000);
      tests_run++;
      if ({acc_v[0], carry_v[0]} !== {4'b1000, 1'b0}) begin
         tests_failed++;
         $display("FAIL add_5_3: got acc=%b c=%b, want acc=1000 c=0", acc_v[0], carry_v[0]);
      end
      @(negedge clk);
      tests_run++;
      if (done_v[0] !== 1'b0) begin
         tests_failed++;
         $display("FAIL done_single_pulse: got %b, want 0", done_v[0]);
      end
   endtask

   task automatic test_carry_zero;
      exec(0, 8'b000_0_1111);
      exec(0, 8'b001_0_0001);
      exec(0, 8'b010_0_0000);
      tests_run++;
      if ({acc_v[0], carry_v[0], zero_of(0)} !== {4'b0000, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL add_wrap: got acc=%b c=%b z=%b, want acc=0000 c=1 z=1", acc_v[0], carry_v[0], zero_of(0));
      end
      exec(0, 8'b001_0_1111);
      exec(0, 8'b110_0_0000);
      tests_run++;
      if ({acc_v[0], carry_v[0], zero_of(0)} !== {4'b1111, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL xor_keeps_carry: got acc=%b c=%b z=%b, want acc=1111 c=1 z=0", acc_v[0], carry_v[0], zero_of(0));
      end
   endtask

   task automatic test_mov;
      exec(0, 8'b000_0_1010);
      exec(0, 8'b001_0_0101);
      exec(0, 8'b111_0_0000);
      tests_run++;
      if ({acc_v[0], carry_v[0], a_v[0]} !== {4'b0101, 1'b1, 4'b0101}) begin
         tests_failed++;
         $display("FAIL mov: got acc=%b c=%b alu_a=%b, want acc=0101 c=1 alu_a=0101", acc_v[0], carry_v[0], a_v[0]);
      end
   endtask

   task automatic test_back_to_back;
      exec(0, 8'b000_0_0001);
      exec(0, 8'b001_0_0010);
      exec(0, 8'b000_0_0000);
      exec(0, 8'b011_1_0000);
   endtask

   // valid held high throughout: the queued LDA must wait for the SUB to retire
   task automatic test_hold_valid;
      exec(1, 8'b000_0_0110);
      exec(1, 8'b001_0_0011);
      valid_v[1] = 1'b1;
      instr_v[1] = 8'b011_0_0000;
      @(negedge clk);
      instr_v[1] = 8'b000_0_1001;
      for (int k = 0; k < 3; k++) begin
         if (k != 0) @(negedge clk);
         tests_run++;
         if ({a_v[1], b_v[1], sel_v[1], ready_v[1], acc_v[1]} !== {4'h6, 4'h3, 3'b011, 1'b0, 4'h6}) begin
            tests_failed++;
            $display("FAIL hold_valid_busy cyc%0d: got a=%h b=%h sel=%h rdy=%b acc=%h, want a=6 b=3 sel=3 rdy=0 acc=6",
                     k, a_v[1], b_v[1], sel_v[1], ready_v[1], acc_v[1]);
         end
      end
      @(negedge clk);
      tests_run++;
      if ({acc_v[1], carry_v[1], done_v[1], ready_v[1]} !== {4'h3, 1'b0, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL sub_capture: got acc=%h c=%b done=%b rdy=%b, want acc=3 c=0 done=1 rdy=1",
                  acc_v[1], carry_v[1], done_v[1], ready_v[1]);
      end
      @(negedge clk);
      valid_v[1] = 1'b0;
      tests_run++;
      if ({acc_v[1], done_v[1], ready_v[1]} !== {4'h9, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL queued_lda: got acc=%h done=%b rdy=%b, want acc=9 done=1 rdy=1", acc_v[1], done_v[1], ready_v[1]);
      end
      m_a[1] = 4'h9; m_c[1] = 1'b0; m_z[1] = 1'b0;
   endtask

   task automatic test_reset_mid_op;
      exec(1, 8'b000_0_1111);
      exec(1, 8'b001_0_0001);
      exec(1, 8'b010_0_0000);
      exec(1, 8'b000_0_0101);
      exec(1, 8'b001_0_0010);
      valid_v[1] = 1'b1;
      instr_v[1] = 8'b010_1_0000;
      @(negedge clk);
      valid_v[1] = 1'b0;
      @(negedge clk);
      rst_v[1] = 1'b1;
      @(negedge clk);
      rst_v[1] = 1'b0;
      model_reset(1);
      tests_run++;
      if ({acc_v[1], breg_v[1], carry_v[1], done_v[1], ready_v[1], sel_v[1]} !==
          {4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 3'b000}) begin
         tests_failed++;
         $display("FAIL reset_mid_op: got acc=%h b=%h c=%b done=%b rdy=%b sel=%h, want 0 0 0 0 1 0",
                  acc_v[1], breg_v[1], carry_v[1], done_v[1], ready_v[1], sel_v[1]);
      end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests_run++;
         if ({done_v[1], acc_v[1]} !== {1'b0, 4'h0}) begin
            tests_failed++;
            $display("FAIL no_writeback_after_reset cyc%0d: got done=%b acc=%h, want done=0 acc=0", k, done_v[1], acc_v[1]);
         end
      end
   endtask

   task automatic test_random;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 60; i++) begin
            exec(d, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 3) == 0) begin
               @(negedge clk);
               tests_run++;
               if ({done_v[d], ready_v[d]} !== 2'b01) begin
                  tests_failed++;
                  $display("FAIL idle_gap dut%0d: got done=%b rdy=%b, want done=0 rdy=1", d, done_v[d], ready_v[d]);
               end
            end
         end
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_v[d]   = 1'b1;
         valid_v[d] = 1'b0;
         instr_v[d] = '0;
      end
      test_reset;
      test_add;
      test_carry_zero;
      test_mov;
      test_back_to_back;
      test_hold_valid;
      test_reset_mid_op;
      test_random;
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
